s_tile_regfile: RTL and testbench

S_TILE_REGFILE -- requirements
Module: s_tile_regfile

---
 rtl/s_tile_pkg.sv | 20 ++
 rtl/s_tile_regfile_port.sv | 125 ++++++++++++
 rtl/s_tile_regfile.sv | 141 ++++++++++++++
 tb/tb_s_tile_regfile.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_tile_pkg.sv
// Shared types and constants for the S-tile register file.
// Build option: define S_TILE_REGFILE_ERR_EN to add the sticky err_o output.
package s_tile_pkg;

  localparam int WORD_W = 16;
  localparam int SET_W  = 2 * WORD_W;

  // Per-port transaction FSM.
  // Handshake: the initiator raises read or write and holds it until it sees
  // the one-cycle ack; ack arrives ACK_LAT cycles after the request first
  // rose. Holding the request past the ack parks the port in HOLD (no second
  // ack) until both request lines are low.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } port_state_e;

endpackage

// File: rtl/s_tile_regfile_port.sv
// One access port: request FSM, latency counter, latched request and
// held read data. Build option: S_TILE_REGFILE_ERR_EN adds o_err_set.
module s_tile_regfile_port
  import s_tile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SET_IDX_W  = 3,
  parameter int ACK_LAT    = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [SET_IDX_W-1:0]  i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_in_range,
  input  logic [DATA_WIDTH-1:0] i_set_val,
  output logic                  o_ack,
  output logic                  o_commit,
  output logic [SET_IDX_W-1:0]  o_idx,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output port_state_e           o_state
`ifdef S_TILE_REGFILE_ERR_EN
  ,
  output logic                  o_err_set
`endif
);

  localparam int CNT_W = (ACK_LAT > 1) ? $clog2(ACK_LAT) : 1;

  port_state_e           r_state, w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_is_write, r_is_read, r_bad;
  logic [SET_IDX_W-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic                  w_req, w_accept, w_bad, w_req_write, w_req_read;
  logic                  w_ack, w_rd_ack;
  logic [DATA_WIDTH-1:0] w_rval;

  assign w_req = i_read | i_write;

`ifdef S_TILE_REGFILE_ERR_EN
  // Read+write together is an error: acked, no write, reads back 0.
  assign w_bad       = ~i_in_range | (i_read & i_write);
  assign w_req_write = i_write & ~i_read;
  assign w_req_read  = i_read;
  assign o_err_set   = w_accept & w_bad;
`else
  // Read+write together behaves as a write.
  assign w_bad       = ~i_in_range;
  assign w_req_write = i_write;
  assign w_req_read  = i_read & ~i_write;
`endif

  // Next-state decode; a dropped request in WAIT abandons the transaction.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_next_state = (ACK_LAT == 1) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!w_req)                   w_next_state = ST_IDLE;
        else if (r_cnt == CNT_W'(1))  w_next_state = ST_ACK;
      end
      ST_ACK:  w_next_state = w_req ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!w_req) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept)                r_cnt <= CNT_W'(ACK_LAT - 1);
      else if (r_state == ST_WAIT) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_is_write <= 1'b0;
      r_is_read  <= 1'b0;
      r_bad      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_is_write <= w_req_write;
      r_is_read  <= w_req_read;
      r_bad      <= w_bad;
      r_idx      <= i_idx;
      r_wdata    <= i_wdata;
    end
  end

  assign w_ack    = (r_state == ST_ACK);
  assign w_rd_ack = w_ack & r_is_read;
  assign w_rval   = r_bad ? '0 : i_set_val;

  // Hold the last read value until the next read ack on this port.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)     r_rdata <= '0;
    else if (w_rd_ack) r_rdata <= w_rval;
  end

  // During the ack cycle the storage value is shown directly, so it
  // reflects every commit made before this cycle but none made at its end.
  assign o_rdata  = w_rd_ack ? w_rval : r_rdata;
  assign o_ack    = w_ack;
  assign o_commit = w_ack & r_is_write & ~r_bad;
  assign o_idx    = r_idx;
  assign o_wdata  = r_wdata;
  assign o_state  = r_state;

endmodule

// File: rtl/s_tile_regfile.sv
// S-tile register file: 2*NUM_SETS 16-bit words, two handshake ports that
// access 32-bit sets, and a host word-write port. Word 0 is the FU config.
// Build option: S_TILE_REGFILE_ERR_EN adds the sticky err_o output.
module s_tile_regfile
  import s_tile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 8,
  parameter int SET_IDX_W  = 3,
  parameter int ACK_LAT    = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  reg_read1_i,
  input  logic                  reg_write1_i,
  input  logic [SET_IDX_W-1:0]  reg_set1_idx_i,
  input  logic [DATA_WIDTH-1:0] reg_data1_i,
  output logic [DATA_WIDTH-1:0] reg_data1_o,
  output logic                  reg_ack1_o,
  input  logic                  reg_read2_i,
  input  logic                  reg_write2_i,
  input  logic [SET_IDX_W-1:0]  reg_set2_idx_i,
  input  logic [DATA_WIDTH-1:0] reg_data2_i,
  output logic [DATA_WIDTH-1:0] reg_data2_o,
  output logic                  reg_ack2_o,
  input  logic                  host_we_i,
  input  logic [3:0]            host_addr_i,
  input  logic [WORD_W-1:0]     host_wdata_i,
  output logic [WORD_W-1:0]     config_o,
  output port_state_e           dbg_state1_o,
  output port_state_e           dbg_state2_o
`ifdef S_TILE_REGFILE_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int NUM_WORDS = 2 * NUM_SETS;

  logic [WORD_W-1:0]     r_mem [NUM_WORDS];
  logic                  w_p1_in_range, w_p2_in_range;
  logic [DATA_WIDTH-1:0] w_p1_set_val, w_p2_set_val;
  logic                  w_p1_commit, w_p2_commit;
  logic [SET_IDX_W-1:0]  w_p1_idx, w_p2_idx;
  logic [DATA_WIDTH-1:0] w_p1_wdata, w_p2_wdata;
`ifdef S_TILE_REGFILE_ERR_EN
  logic                  w_p1_err_set, w_p2_err_set, r_err;
`endif

  // Range check of incoming indices and set lookup for latched indices.
  always_comb begin
    w_p1_in_range = 1'b0;
    w_p2_in_range = 1'b0;
    w_p1_set_val  = '0;
    w_p2_set_val  = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      if (reg_set1_idx_i == SET_IDX_W'(s)) w_p1_in_range = 1'b1;
      if (reg_set2_idx_i == SET_IDX_W'(s)) w_p2_in_range = 1'b1;
      if (w_p1_idx == SET_IDX_W'(s)) w_p1_set_val = DATA_WIDTH'({r_mem[2*s+1], r_mem[2*s]});
      if (w_p2_idx == SET_IDX_W'(s)) w_p2_set_val = DATA_WIDTH'({r_mem[2*s+1], r_mem[2*s]});
    end
  end

  s_tile_regfile_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .SET_IDX_W  (SET_IDX_W),
    .ACK_LAT    (ACK_LAT)
  ) u_port1 (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .i_read     (reg_read1_i),
    .i_write    (reg_write1_i),
    .i_idx      (reg_set1_idx_i),
    .i_wdata    (reg_data1_i),
    .i_in_range (w_p1_in_range),
    .i_set_val  (w_p1_set_val),
    .o_ack      (reg_ack1_o),
    .o_commit   (w_p1_commit),
    .o_idx      (w_p1_idx),
    .o_wdata    (w_p1_wdata),
    .o_rdata    (reg_data1_o),
    .o_state    (dbg_state1_o)
`ifdef S_TILE_REGFILE_ERR_EN
    ,
    .o_err_set  (w_p1_err_set)
`endif
  );

  s_tile_regfile_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .SET_IDX_W  (SET_IDX_W),
    .ACK_LAT    (ACK_LAT)
  ) u_port2 (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .i_read     (reg_read2_i),
    .i_write    (reg_write2_i),
    .i_idx      (reg_set2_idx_i),
    .i_wdata    (reg_data2_i),
    .i_in_range (w_p2_in_range),
    .i_set_val  (w_p2_set_val),
    .o_ack      (reg_ack2_o),
    .o_commit   (w_p2_commit),
    .o_idx      (w_p2_idx),
    .o_wdata    (w_p2_wdata),
    .o_rdata    (reg_data2_o),
    .o_state    (dbg_state2_o)
`ifdef S_TILE_REGFILE_ERR_EN
    ,
    .o_err_set  (w_p2_err_set)
`endif
  );

  // Word storage; priority host > port 1 > port 2 on the same word.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int w = 0; w < NUM_WORDS; w++) r_mem[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (host_we_i && host_addr_i == 4'(w))
          r_mem[w] <= host_wdata_i;
        else if (w_p1_commit && w_p1_idx == SET_IDX_W'(w / 2))
          r_mem[w] <= w_p1_wdata[(w % 2)*WORD_W +: WORD_W];
        else if (w_p2_commit && w_p2_idx == SET_IDX_W'(w / 2))
          r_mem[w] <= w_p2_wdata[(w % 2)*WORD_W +: WORD_W];
      end
    end
  end

  assign config_o = r_mem[0];

`ifdef S_TILE_REGFILE_ERR_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                         r_err <= 1'b0;
    else if (w_p1_err_set | w_p2_err_set)  r_err <= 1'b1;
  end
  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_s_tile_regfile.sv
// Bench for s_tile_regfile: a 6-set, 3-cycle-latency instance carries the
// table, directed and randomized tests; a default 1-cycle instance covers
// the single-cycle acknowledge path.
module tb_s_tile_regfile;
  import s_tile_pkg::*;

  localparam int DW  = 32;
  localparam int NS  = 6;
  localparam int IW  = 3;
  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic          rd1, wr1, rd2, wr2, ack1, ack2, hwe;
  logic [IW-1:0] idx1, idx2;
  logic [DW-1:0] wd1, wd2, rdat1, rdat2;
  logic [3:0]    haddr;
  logic [15:0]   hwd, cfg;
  port_state_e   st1, st2;
  // single-cycle instance signals
  logic          b_rd1, b_wr1, b_rd2, b_wr2, b_ack1, b_ack2, b_hwe;
  logic [2:0]    b_idx1, b_idx2;
  logic [31:0]   b_wd1, b_wd2, b_rdat1, b_rdat2;
  logic [3:0]    b_haddr;
  logic [15:0]   b_hwd, b_cfg;
  port_state_e   b_st1, b_st2;
`ifdef S_TILE_REGFILE_ERR_EN
  logic          err_a, err_b;
`endif

  s_tile_regfile #(.DATA_WIDTH(DW), .NUM_SETS(NS), .SET_IDX_W(IW), .ACK_LAT(LAT)) u_dut (
    .clk_i(clk), .reset_ni(rst_n),
    .reg_read1_i(rd1), .reg_write1_i(wr1), .reg_set1_idx_i(idx1), .reg_data1_i(wd1),
    .reg_data1_o(rdat1), .reg_ack1_o(ack1),
    .reg_read2_i(rd2), .reg_write2_i(wr2), .reg_set2_idx_i(idx2), .reg_data2_i(wd2),
    .reg_data2_o(rdat2), .reg_ack2_o(ack2),
    .host_we_i(hwe), .host_addr_i(haddr), .host_wdata_i(hwd), .config_o(cfg),
    .dbg_state1_o(st1), .dbg_state2_o(st2)
`ifdef S_TILE_REGFILE_ERR_EN
    , .err_o(err_a)
`endif
  );

  s_tile_regfile u_dut_lat1 (
    .clk_i(clk), .reset_ni(rst_n),
    .reg_read1_i(b_rd1), .reg_write1_i(b_wr1), .reg_set1_idx_i(b_idx1), .reg_data1_i(b_wd1),
    .reg_data1_o(b_rdat1), .reg_ack1_o(b_ack1),
    .reg_read2_i(b_rd2), .reg_write2_i(b_wr2), .reg_set2_idx_i(b_idx2), .reg_data2_i(b_wd2),
    .reg_data2_o(b_rdat2), .reg_ack2_o(b_ack2),
    .host_we_i(b_hwe), .host_addr_i(b_haddr), .host_wdata_i(b_hwd), .config_o(b_cfg),
    .dbg_state1_o(b_st1), .dbg_state2_o(b_st2)
`ifdef S_TILE_REGFILE_ERR_EN
    , .err_o(err_b)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_port(input int p, input logic rd, input logic wr,
                            input logic [IW-1:0] idx, input logic [DW-1:0] d);
    if (p == 0) begin rd1 = rd; wr1 = wr; idx1 = idx; wd1 = d; end
    else        begin rd2 = rd; wr2 = wr; idx2 = idx; wd2 = d; end
  endtask

  function automatic logic out_ack(input int p);
    return (p == 0) ? ack1 : ack2;
  endfunction

  function automatic logic [DW-1:0] out_rdata(input int p);
    return (p == 0) ? rdat1 : rdat2;
  endfunction

  // Full transaction on the main instance: request, wait (bounded) for the
  // ack, drop, then one idle cycle so the next request starts from IDLE.
  task automatic a_txn(input int p, input logic rd, input logic wr, input logic [IW-1:0] idx,
                       input logic [DW-1:0] d, output int ack_at, output logic [DW-1:0] rdat);
    ack_at = -1;
    rdat   = '0;
    drive_port(p, rd, wr, idx, d);
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (out_ack(p) === 1'b1) begin
        ack_at = k;
        rdat   = out_rdata(p);
        break;
      end
    end
    drive_port(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d);
    hwe = 1'b1; haddr = a; hwd = d;
    @(negedge clk);
    hwe = 1'b0;
  endtask

  // ---------------- reference model storage ----------------
  logic [15:0] mem [16];

  function automatic logic [31:0] model_set(input logic [IW-1:0] i);
    int ii;
    ii = int'(i);
    if (ii < NS) return {mem[2*ii+1], mem[2*ii]};
    return 32'h0;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  a_lo;
    logic [15:0] d_lo;
    logic [3:0]  a_hi;
    logic [15:0] d_hi;
    int          port;
    logic [2:0]  set;
    logic [31:0] exp_data;
    logic [15:0] exp_cfg;
  } vec_t;

  vec_t tbl [6];

  // ---------------- main sequence ----------------
  initial begin
    int          ack_at;
    logic [31:0] rdat;
    int          ph [2];
    int          st_cyc [2];
    int          hold_left [2];
    bit          m_wr [2];
    bit          exp_ack [2];
    logic [2:0]  m_idx [2];
    logic [31:0] m_d [2];
    logic [31:0] last_rd [2];
    int          op;

    tbl[0] = '{4'd0,  16'h00F0, 4'd1,  16'h0F00, 0, 3'd0, 32'h0F0000F0, 16'h00F0};
    tbl[1] = '{4'd10, 16'h5555, 4'd11, 16'hAAAA, 1, 3'd5, 32'hAAAA5555, 16'h00F0};
    tbl[2] = '{4'd8,  16'hFFFF, 4'd9,  16'h0001, 0, 3'd4, 32'h0001FFFF, 16'h00F0};
    tbl[3] = '{4'd12, 16'h1111, 4'd13, 16'h2222, 0, 3'd6, 32'h00000000, 16'h00F0};
    tbl[4] = '{4'd14, 16'h0003, 4'd15, 16'h0004, 1, 3'd7, 32'h00000000, 16'h00F0};
    tbl[5] = '{4'd2,  16'h1234, 4'd3,  16'hABCD, 1, 3'd1, 32'hABCD1234, 16'h00F0};

    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    hwe = 0; haddr = '0; hwd = '0;
    b_rd1 = 0; b_wr1 = 0; b_idx1 = '0; b_wd1 = '0;
    b_rd2 = 0; b_wr2 = 0; b_idx2 = '0; b_wd2 = '0;
    b_hwe = 0; b_haddr = '0; b_hwd = '0;

    // reset state
    #12;
    chk("rst_data1", rdat1, 32'h0);
    chk("rst_data2", rdat2, 32'h0);
    chk("rst_ack", {30'b0, ack1, ack2}, 32'h0);
    chk("rst_cfg", {16'b0, cfg}, 32'h0);
    chk("rst_state", {28'b0, st1, st2}, 32'h0);
    chk("rst_lat1_out", b_rdat1 | b_rdat2 | {16'b0, b_cfg}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single-cycle instance: host words 2/3 then read set 1
    b_hwe = 1; b_haddr = 4'd2; b_hwd = 16'h1234;
    @(negedge clk);
    b_haddr = 4'd3; b_hwd = 16'hABCD;
    @(negedge clk);
    b_hwe = 0;
    b_rd1 = 1; b_idx1 = 3'd1;
    @(negedge clk);
    chk("l1_read_ack", {31'b0, b_ack1}, 32'h1);
    chk("l1_read_data", b_rdat1, 32'hABCD1234);
    b_rd1 = 0;
    @(negedge clk);
    chk("l1_ack_single", {31'b0, b_ack1}, 32'h0);
    chk("l1_data_hold", b_rdat1, 32'hABCD1234);
    b_wr2 = 1; b_idx2 = 3'd7; b_wd2 = 32'h0BADCAFE;
    @(negedge clk);
    chk("l1_write_ack", {31'b0, b_ack2}, 32'h1);
    b_wr2 = 0;
    @(negedge clk);
    b_rd1 = 1; b_idx1 = 3'd7;
    @(negedge clk);
    chk("l1_readback", b_rdat1, 32'h0BADCAFE);
    b_rd1 = 0;
    @(negedge clk);

    // table: host writes two words, a port reads the set back
    for (int i = 0; i < 6; i++) begin
      host_write(tbl[i].a_lo, tbl[i].d_lo);
      host_write(tbl[i].a_hi, tbl[i].d_hi);
      a_txn(tbl[i].port, 1'b1, 1'b0, tbl[i].set, '0, ack_at, rdat);
      chk("tbl_latency", ack_at, LAT);
      chk("tbl_rdata", rdat, tbl[i].exp_data);
      chk("tbl_cfg", {16'b0, cfg}, {16'b0, tbl[i].exp_cfg});
    end

    // port 2 write with exact ack timing, read back on port 2
    drive_port(1, 1'b0, 1'b1, 3'd5, 32'hDEADBEEF);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk("wr_ack_timing", {31'b0, ack2}, (k == LAT) ? 32'h1 : 32'h0);
      if (k == LAT) drive_port(1, 0, 0, '0, '0);
    end
    a_txn(1, 1'b1, 1'b0, 3'd5, '0, ack_at, rdat);
    chk("wr_readback", rdat, 32'hDEADBEEF);

    // both ports commit set 4 on the same edge: port 1 wins, both acked
    drive_port(0, 1'b0, 1'b1, 3'd4, 32'h11111111);
    drive_port(1, 1'b0, 1'b1, 3'd4, 32'h22222222);
    repeat (LAT) @(negedge clk);
    chk("dual_ack", {30'b0, ack1, ack2}, 32'h3);
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    @(negedge clk);
    chk("dual_ack_gone", {30'b0, ack1, ack2}, 32'h0);
    a_txn(1, 1'b1, 1'b0, 3'd4, '0, ack_at, rdat);
    chk("dual_winner", rdat, 32'h11111111);

    // request held past the ack: one pulse, HOLD, switching to write is ignored
    drive_port(0, 1'b1, 1'b0, 3'd4, '0);
    repeat (LAT) @(negedge clk);
    chk("hold_first_ack", {31'b0, ack1}, 32'h1);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("hold_no_ack", {31'b0, ack1}, 32'h0);
      chk("hold_state", 32'(st1), 32'(ST_HOLD));
      if (h == 2) drive_port(0, 1'b0, 1'b1, 3'd4, 32'h99999999);
    end
    drive_port(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("hold_release", 32'(st1), 32'(ST_IDLE));
    a_txn(0, 1'b1, 1'b0, 3'd4, '0, ack_at, rdat);
    chk("hold_no_write", rdat, 32'h11111111);

    // write request dropped in WAIT: no ack, no write
    drive_port(0, 1'b0, 1'b1, 3'd3, 32'h77777777);
    @(negedge clk);
    @(negedge clk);
    drive_port(0, 0, 0, '0, '0);
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("drop_no_ack", {31'b0, ack1}, 32'h0);
    end
    a_txn(0, 1'b1, 1'b0, 3'd3, '0, ack_at, rdat);
    chk("drop_set_kept", rdat, 32'h0);

    // host write to word 8 on the same edge as port 1 commits set 4
    drive_port(0, 1'b0, 1'b1, 3'd4, 32'hCAFEF00D);
    repeat (LAT) @(negedge clk);
    chk("ovr_ack", {31'b0, ack1}, 32'h1);
    drive_port(0, 0, 0, '0, '0);
    host_write(4'd8, 16'h5A5A);
    a_txn(0, 1'b1, 1'b0, 3'd4, '0, ack_at, rdat);
    chk("host_override", rdat, 32'hCAFE5A5A);

    // reset in the middle of WAIT clears everything immediately
    drive_port(0, 1'b1, 1'b0, 3'd5, '0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", rdat1 | rdat2, 32'h0);
    chk("arst_ack", {30'b0, ack1, ack2}, 32'h0);
    chk("arst_cfg", {16'b0, cfg}, 32'h0);
    chk("arst_state", 32'(st1), 32'(ST_IDLE));
    chk("arst_lat1", b_rdat1 | {16'b0, b_cfg}, 32'h0);
    drive_port(0, 0, 0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      chk("arst_no_ack", {31'b0, ack1}, 32'h0);
    end

    // randomized traffic against the transaction-level model
    for (int w = 0; w < 16; w++) mem[w] = 16'h0;
    for (int p = 0; p < 2; p++) begin
      ph[p] = 0; st_cyc[p] = 0; hold_left[p] = 0; m_wr[p] = 0;
      m_idx[p] = '0; m_d[p] = '0; last_rd[p] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        exp_ack[p] = (ph[p] == 1) && (cyc == st_cyc[p] + LAT);
        chk("rnd_ack", {31'b0, out_ack(p)}, {31'b0, exp_ack[p]});
        if (exp_ack[p] && !m_wr[p]) last_rd[p] = model_set(m_idx[p]);
        chk("rnd_rdata", out_rdata(p), last_rd[p]);
      end
      chk("rnd_cfg", {16'b0, cfg}, {16'b0, mem[0]});
      // commits landing on the coming edge: port 2, then port 1, then host
      for (int p = 1; p >= 0; p--) begin
        if (exp_ack[p] && m_wr[p] && int'(m_idx[p]) < NS) begin
          mem[2*int'(m_idx[p])]   = m_d[p][15:0];
          mem[2*int'(m_idx[p])+1] = m_d[p][31:16];
        end
      end
      hwe   = ($urandom_range(0, 3) == 0);
      haddr = 4'($urandom_range(0, 15));
      hwd   = 16'($urandom);
      if (hwe && int'(haddr) < 2*NS) mem[haddr] = hwd;
      // initiator behaviour for this cycle
      for (int p = 0; p < 2; p++) begin
        case (ph[p])
          1: begin
            if (exp_ack[p]) begin
              if ($urandom_range(0, 3) == 0) begin
                ph[p] = 2;
                hold_left[p] = $urandom_range(1, 4);
              end else begin
                ph[p] = 0;
                drive_port(p, 0, 0, '0, '0);
              end
            end else if ($urandom_range(0, 15) == 0) begin
              ph[p] = 0;
              drive_port(p, 0, 0, '0, '0);
            end
          end
          2: begin
            hold_left[p]--;
            if (hold_left[p] == 0) begin
              ph[p] = 0;
              drive_port(p, 0, 0, '0, '0);
            end
          end
          default: begin
            if ($urandom_range(0, 1) == 1) begin
              op        = $urandom_range(0, 2);
              m_wr[p]   = (op != 0);
              m_idx[p]  = 3'($urandom_range(0, 7));
              m_d[p]    = $urandom;
              st_cyc[p] = cyc;
              ph[p]     = 1;
              drive_port(p, (op != 1), (op != 0), m_idx[p], m_d[p]);
            end
          end
        endcase
      end
    end
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    hwe = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
